// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: memory operations, exception codes and helpers.
// Imported by the LSU and the data-memory responder.
package riscv_pkg;

    localparam int EXC_W = 5;

    typedef enum logic [3:0] {
        MEM_LB  = 4'b0000,
        MEM_LH  = 4'b0001,
        MEM_LW  = 4'b0010,
        MEM_LBU = 4'b0100,
        MEM_LHU = 4'b0101,
        MEM_SB  = 4'b1000,
        MEM_SH  = 4'b1001,
        MEM_SW  = 4'b1010,
        MEM_NOP = 4'b1111
    } mem_oper_t;

    typedef enum logic [EXC_W-1:0] {
        INSTR_ADDR_MISALIGNED     = 5'd0,
        INSTR_ACC_FAULT           = 5'd1,
        ILLEGAL_INSTR             = 5'd2,
        BREAKPOINT                = 5'd3,
        LOAD_ADDR_MISALIGNED      = 5'd4,
        LOAD_ACC_FAULT            = 5'd5,
        STORE_AMO_ADDR_MISALIGNED = 5'd6,
        STORE_AMO_ACC_FAULT       = 5'd7,
        NO_TRAP                   = 5'b10000
    } exc_t;

    function automatic logic mem_is_store(mem_oper_t op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic mem_is_load(mem_oper_t op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW,
            MEM_LBU, MEM_LHU: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store enables and replicated
// write data, load extraction with sign/zero extension, misalign detect.
module dmem_lane_align
    import riscv_pkg::*;
(
    input  logic [3:0]  oper_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misal_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rword_i[{addr_i, 3'b000} +: 8];
    assign half_s = addr_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        be_o    = 4'b0000;
        wword_o = wdata_i;
        rdata_o = '0;
        misal_o = 1'b0;
        case (oper_i)
            MEM_LB:  rdata_o = {{24{byte_s[7]}}, byte_s};
            MEM_LBU: rdata_o = {24'h0, byte_s};
            MEM_LH: begin
                rdata_o = {{16{half_s[15]}}, half_s};
                misal_o = addr_i[0];
            end
            MEM_LHU: begin
                rdata_o = {16'h0, half_s};
                misal_o = addr_i[0];
            end
            MEM_LW: begin
                rdata_o = rword_i;
                misal_o = |addr_i;
            end
            MEM_SB: begin
                be_o    = 4'b0001 << addr_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            MEM_SH: begin
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
                misal_o = addr_i[0];
            end
            MEM_SW: begin
                be_o    = 4'b1111;
                misal_o = |addr_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// LSU-facing data-memory responder: one request in flight, word RAM behind.
// Optional performance counters are built when DMEM_PERF_CNT_EN is defined.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_oper_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_rdata_o,
`ifdef DMEM_PERF_CNT_EN
    output logic [31:0]      perf_loads_o,
    output logic [31:0]      perf_stores_o,
    output logic [31:0]      perf_faults_o,
`endif
    output logic [EXC_W-1:0] rsp_exc_o
);

    typedef logic [1:0] dmem_state_t;
    localparam dmem_state_t IDLE = 2'd0;
    localparam dmem_state_t WAIT = 2'd1;
    localparam dmem_state_t EXEC = 2'd2;
    localparam dmem_state_t RESP = 2'd3;

    localparam int          AW     = $clog2(DEPTH_WORDS * 4);
    localparam int          IW     = AW - 2;
    localparam logic [31:0] SPAN_B = 32'(DEPTH_WORDS * 4);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  oper_q, oper_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    exc_t        exc_q, exc_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] off, rword, wword, ldata;
    logic [IW-1:0] widx;
    logic [3:0]  be;
    logic        misal, oor, undef, we;
    exc_t        chk_exc;

    assign off   = addr_q - BASE_ADDR;
    assign widx  = off[AW-1:2];
    assign rword = mem[widx];
    assign oor   = off >= SPAN_B;

    dmem_lane_align u_align (
        .oper_i  (oper_q),
        .addr_i  (addr_q[1:0]),
        .wdata_i (wdata_q),
        .rword_i (rword),
        .be_o    (be),
        .wword_o (wword),
        .rdata_o (ldata),
        .misal_o (misal)
    );

    // Fault codes split on the operation MSB, which also covers undefined encodings.
    always_comb begin
        undef = !(mem_is_load(mem_oper_t'(oper_q)) ||
                  mem_is_store(mem_oper_t'(oper_q)) ||
                  oper_q == MEM_NOP);
        chk_exc = NO_TRAP;
        if (oper_q == MEM_NOP)
            chk_exc = NO_TRAP;
        else if (misal)
            chk_exc = oper_q[3] ? STORE_AMO_ADDR_MISALIGNED : LOAD_ADDR_MISALIGNED;
        else if (oor || undef)
            chk_exc = oper_q[3] ? STORE_AMO_ACC_FAULT : LOAD_ACC_FAULT;
    end

    assign we = (state_q == EXEC) && (chk_exc == NO_TRAP) &&
                mem_is_store(mem_oper_t'(oper_q));

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oper_d  = oper_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                oper_d  = req_oper_i;
                addr_d  = req_addr_i;
                wdata_d = req_wdata_i;
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = (WAIT_CYCLES > 0) ? WAIT : EXEC;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = EXEC;
            end
            EXEC: begin
                rdata_d = (chk_exc == NO_TRAP) ? ldata : '0;
                exc_d   = chk_exc;
                state_d = RESP;
            end
            default: if (rsp_ready_i) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            oper_q  <= MEM_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            exc_q   <= NO_TRAP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oper_q  <= oper_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_exc_o   = exc_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] pl_q, pl_d, ps_q, ps_d, pf_q, pf_d;
    logic        hs;

    assign hs = (state_q == RESP) && rsp_ready_i;

    always_comb begin
        pl_d = pl_q;
        ps_d = ps_q;
        pf_d = pf_q;
        if (hs) begin
            if (exc_q != NO_TRAP)
                pf_d = pf_q + 32'd1;
            else if (mem_is_load(mem_oper_t'(oper_q)))
                pl_d = pl_q + 32'd1;
            else if (mem_is_store(mem_oper_t'(oper_q)))
                ps_d = ps_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pl_q <= '0;
            ps_q <= '0;
            pf_q <= '0;
        end else begin
            pl_q <= pl_d;
            ps_q <= ps_d;
            pf_q <= pf_d;
        end
    end

    assign perf_loads_o  = pl_q;
    assign perf_stores_o = ps_q;
    assign perf_faults_o = pf_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array memory model,
// run on a 3-wait-state instance and a zero-wait-state instance.
module tb_dmem_responder;

    localparam int          DW   = 64;
    localparam int          SPAN = DW * 4;
    localparam logic [31:0] BASE = 32'h8000_0000;

    localparam logic [3:0] O_LB  = 4'h0, O_LH  = 4'h1, O_LW  = 4'h2;
    localparam logic [3:0] O_LBU = 4'h4, O_LHU = 4'h5;
    localparam logic [3:0] O_SB  = 4'h8, O_SH  = 4'h9, O_SW  = 4'hA;
    localparam logic [3:0] O_NOP = 4'hF;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  rsp_ready = 2'b00;
    logic [1:0]  req_ready, rsp_valid;
    logic [3:0]  oper = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata [2];
    logic [4:0]  exc [2];
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] pl [2], ps [2], pf [2];
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DW), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_oper_i(oper), .req_addr_i(addr), .req_wdata_i(wdata),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rdata[0]),
`ifdef DMEM_PERF_CNT_EN
        .perf_loads_o(pl[0]), .perf_stores_o(ps[0]), .perf_faults_o(pf[0]),
`endif
        .rsp_exc_o(exc[0])
    );

    dmem_responder #(.DEPTH_WORDS(DW), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_oper_i(oper), .req_addr_i(addr), .req_wdata_i(wdata),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rdata[1]),
`ifdef DMEM_PERF_CNT_EN
        .perf_loads_o(pl[1]), .perf_stores_o(ps[1]), .perf_faults_o(pf[1]),
`endif
        .rsp_exc_o(exc[1])
    );

    int ncmp = 0;
    int nerr = 0;
    logic [7:0] mdl [2][SPAN];
    int mloads [2];
    int mstores [2];
    int mfaults [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wcyc(input int s);
        return (s == 0) ? 3 : 0;
    endfunction

    function automatic void model(input int s, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic [4:0] ex);
        int sz;
        bit ld, st, sgn;
        logic [31:0] off, v;
        sz = 1; ld = 0; st = 0; sgn = 0;
        case (op)
            O_LB:  begin ld = 1; sz = 1; sgn = 1; end
            O_LH:  begin ld = 1; sz = 2; sgn = 1; end
            O_LW:  begin ld = 1; sz = 4; end
            O_LBU: begin ld = 1; sz = 1; end
            O_LHU: begin ld = 1; sz = 2; end
            O_SB:  begin st = 1; sz = 1; end
            O_SH:  begin st = 1; sz = 2; end
            O_SW:  begin st = 1; sz = 4; end
            default: ;
        endcase
        off = a - BASE;
        rd  = '0;
        ex  = 5'h10;
        if (op == O_NOP) return;
        if ((a & 32'(sz - 1)) != 0)
            ex = op[3] ? 5'd6 : 5'd4;
        else if (off >= 32'(SPAN) || !(ld || st))
            ex = op[3] ? 5'd7 : 5'd5;
        else if (st) begin
            for (int i = 0; i < sz; i++) mdl[s][off + 32'(i)] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = mdl[s][off + 32'(i)];
            if (sgn && v[8*sz-1])
                for (int i = 8 * sz; i < 32; i++) v[i] = 1'b1;
            rd = v;
        end
        if (ex != 5'h10) mfaults[s]++;
        else if (ld) mloads[s]++;
        else if (st) mstores[s]++;
    endfunction

    task automatic xact(input int s, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] grd, output logic [4:0] gex);
        logic [31:0] erd;
        logic [4:0]  eex;
        int lat;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready[s]), 1);
        oper = op; addr = a; wdata = wd;
        req_valid[s] = 1'b1;
        @(negedge clk);
        req_valid[s] = 1'b0;
        lat = 1;
        while (!rsp_valid[s] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(wcyc(s) + 2));
        model(s, op, a, wd, erd, eex);
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 32'(rsp_valid[s]), 1);
            chk("hold_req_ready", 32'(req_ready[s]), 0);
            chk("hold_rdata", rdata[s], erd);
            chk("hold_exc", 32'(exc[s]), 32'(eex));
            req_valid[s] = 1'b1;
            oper = 4'($urandom);
            addr = $urandom;
            @(negedge clk);
        end
        req_valid[s] = 1'b0;
        chk("rsp_valid", 32'(rsp_valid[s]), 1);
        chk("rdata", rdata[s], erd);
        chk("exc", 32'(exc[s]), 32'(eex));
        grd = rdata[s];
        gex = exc[s];
        rsp_ready[s] = 1'b1;
        @(negedge clk);
        rsp_ready[s] = 1'b0;
        chk("valid_drop", 32'(rsp_valid[s]), 0);
        chk("rdata_keep", rdata[s], erd);
        chk("exc_keep", 32'(exc[s]), 32'(eex));
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk({tag, "_req_ready"}, 32'(req_ready[s]), 1);
            chk({tag, "_rsp_valid"}, 32'(rsp_valid[s]), 0);
            chk({tag, "_rdata"}, rdata[s], 0);
            chk({tag, "_exc"}, 32'(exc[s]), 32'h10);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r, a;
        logic [4:0]  e;
        logic [3:0]  op;
`ifdef DMEM_PERF_CNT_EN
        logic [31:0] l0, s0, f0;
`endif
        for (int s = 0; s < 2; s++) begin
            mloads[s] = 0; mstores[s] = 0; mfaults[s] = 0;
        end
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_low");
        rstn = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_rel");

        for (int s = 0; s < 2; s++)
            for (int w = 0; w < DW; w++)
                xact(s, O_SW, BASE + 32'(4 * w), $urandom, 0, r, e);

        xact(0, O_SW, BASE + 32'h10, 32'hDEADBEEF, 0, r, e);
        xact(0, O_LB, BASE + 32'h13, 0, 0, r, e);
        chk("lb13", r, 32'hFFFFFFDE);
        chk("lb13_exc", 32'(e), 32'h10);
        xact(0, O_LBU, BASE + 32'h13, 0, 0, r, e);
        chk("lbu13", r, 32'h000000DE);
        xact(0, O_LH, BASE + 32'h12, 0, 0, r, e);
        chk("lh12", r, 32'hFFFFDEAD);
        xact(0, O_LHU, BASE + 32'h10, 0, 0, r, e);
        chk("lhu10", r, 32'h0000BEEF);
        xact(0, O_SB, BASE + 32'h11, 32'h000000AA, 0, r, e);
        xact(0, O_LW, BASE + 32'h10, 0, 0, r, e);
        chk("lw_after_sb", r, 32'hDEADAAEF);
        xact(0, O_SH, BASE + 32'h12, 32'h00001234, 0, r, e);
        xact(0, O_LW, BASE + 32'h10, 0, 0, r, e);
        chk("lw_after_sh", r, 32'h1234AAEF);
        xact(0, O_LW, BASE + 32'h12, 0, 0, r, e);
        chk("lw_mis_exc", 32'(e), 4);
        chk("lw_mis_rdata", r, 0);
        xact(0, O_SH, BASE + 32'h11, 32'hFFFF, 0, r, e);
        chk("sh_mis_exc", 32'(e), 6);
        xact(0, O_LW, BASE + 32'h10, 0, 5, r, e);
        chk("ram_unchanged", r, 32'h1234AAEF);
        xact(0, O_LW, BASE + 32'(SPAN), 0, 0, r, e);
        chk("lw_oor_exc", 32'(e), 5);
        xact(0, O_SW, BASE + 32'(SPAN), 1, 0, r, e);
        chk("sw_oor_exc", 32'(e), 7);
        xact(0, 4'b1100, BASE, 1, 0, r, e);
        chk("undef_exc", 32'(e), 7);
        xact(0, O_SW, BASE + 32'(SPAN) + 1, 1, 0, r, e);
        chk("sw_mis_oor_exc", 32'(e), 6);
        xact(0, O_NOP, 32'h0, 0, 0, r, e);
        chk("nop_exc", 32'(e), 32'h10);
        xact(1, O_SW, BASE + 32'h40, 32'h8765_4321, 0, r, e);
        xact(1, O_LH, BASE + 32'h42, 0, 5, r, e);
        chk("w0_lh42", r, 32'hFFFF8765);

`ifdef DMEM_PERF_CNT_EN
        l0 = pl[0]; s0 = ps[0]; f0 = pf[0];
        xact(0, O_LW, BASE + 32'h10, 0, 0, r, e);
        xact(0, O_LB, BASE + 32'h11, 0, 0, r, e);
        xact(0, O_LHU, BASE + 32'h12, 0, 0, r, e);
        xact(0, O_SW, BASE + 32'h30, 32'h5555_AAAA, 0, r, e);
        xact(0, O_SB, BASE + 32'h31, 32'h77, 0, r, e);
        xact(0, O_LW, BASE + 32'h31, 0, 0, r, e);
        xact(0, O_NOP, BASE, 0, 0, r, e);
        chk("perf_loads_delta", pl[0] - l0, 3);
        chk("perf_stores_delta", ps[0] - s0, 2);
        chk("perf_faults_delta", pf[0] - f0, 1);
`endif

        xact(0, O_SW, BASE + 32'h20, 32'hCAFE_F00D, 0, r, e);
        @(negedge clk);
        oper = O_SW; addr = BASE + 32'h20; wdata = 32'h12345678;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_reset_vals("midwait_low");
        @(negedge clk);
        rstn = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mloads[s] = 0; mstores[s] = 0; mfaults[s] = 0;
        end
        @(negedge clk);
        chk_reset_vals("midwait_rel");
        xact(0, O_LW, BASE + 32'h20, 0, 0, r, e);
        chk("abort_no_write", r, 32'hCAFEF00D);

        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 250; k++) begin
                op = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0)
                    a = $urandom;
                else
                    a = BASE + 32'($urandom_range(0, SPAN - 1));
                if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
                xact(s, op, a, $urandom, $urandom_range(0, 3), r, e);
            end
        end

`ifdef DMEM_PERF_CNT_EN
        for (int s = 0; s < 2; s++) begin
            chk("perf_loads", pl[s], 32'(mloads[s]));
            chk("perf_stores", ps[s], 32'(mstores[s]));
            chk("perf_faults", pf[s], 32'(mfaults[s]));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
